// File: rtl/game_sequencer_if.sv
// Signal bundle between the game-flow controller and the surrounding top level.
// master: frame timing, buttons and object events; slave: the sequencer itself.
interface game_sequencer_if #(
  parameter int NUM_ALIENS = 20,
  parameter int SCORE_W    = 16
);
  localparam int ALIEN_W = $clog2(NUM_ALIENS + 1);

  // Inputs carry no valid/ready pair: fsync, alien_hit and player_hit are
  // single-cycle event pulses consumed on the edge that samples them, fire is
  // a level, and every output is a registered level valid on every cycle.
  logic               fsync;
  logic               fire;
  logic               alien_hit;
  logic               player_hit;
  logic [ALIEN_W-1:0] aliens_remaining;

  logic [2:0]         state;
  logic               player_rst;
  logic               wave_rst;
  logic               freeze;
  logic               game_over;
  logic [3:0]         enemy_speed;
  logic [SCORE_W-1:0] score;
  logic [3:0]         lives;
  logic [7:0]         level;

  modport master (
    output fsync, fire, alien_hit, player_hit, aliens_remaining,
    input  state, player_rst, wave_rst, freeze, game_over,
    input  enemy_speed, score, lives, level
  );

  modport slave (
    input  fsync, fire, alien_hit, player_hit, aliens_remaining,
    output state, player_rst, wave_rst, freeze, game_over,
    output enemy_speed, score, lives, level
  );
endinterface

// File: rtl/game_sequencer.sv
// Game-flow controller: attract/play/wave-clear/dying/game-over sequencing,
// object soft resets and freeze, score, lives, level and per-level alien speed.
module game_sequencer #(
  parameter int NUM_ALIENS    = 20,
  parameter int START_LIVES   = 3,
  parameter int SPEED_INIT    = 1,
  parameter int SPEED_MAX     = 6,
  parameter int SCORE_PER_HIT = 10,
  parameter int SCORE_W       = 16,
  parameter int CLEAR_FRAMES  = 120,
  parameter int DEATH_FRAMES  = 90
) (
  input  logic              pixel_clk,
  input  logic              rst,
  game_sequencer_if.slave   bus
);

  typedef enum logic [2:0] {
    ST_ATTRACT    = 3'd0,
    ST_PLAY       = 3'd1,
    ST_WAVE_CLEAR = 3'd2,
    ST_DYING      = 3'd3,
    ST_GAME_OVER  = 3'd4
  } state_t;

  localparam int ALIEN_W = $clog2(NUM_ALIENS + 1);
  localparam int CNT_MAX = (CLEAR_FRAMES > DEATH_FRAMES) ? CLEAR_FRAMES : DEATH_FRAMES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  localparam logic [CNT_W-1:0]   CNT_SAT     = CNT_W'(CNT_MAX);
  localparam logic [CNT_W-1:0]   CLEAR_LAST  = CNT_W'(CLEAR_FRAMES - 1);
  localparam logic [CNT_W-1:0]   DEATH_LAST  = CNT_W'(DEATH_FRAMES - 1);
  localparam logic [CNT_W-1:0]   DEATH_DONE  = CNT_W'(DEATH_FRAMES);
  localparam logic [3:0]         LIVES_INIT  = 4'(START_LIVES);
  localparam logic [SCORE_W:0]   HIT_INC     = (SCORE_W + 1)'(SCORE_PER_HIT);
  localparam logic [8:0]         SPEED_BASE  = 9'(SPEED_INIT);
  localparam logic [8:0]         SPEED_CAP   = 9'(SPEED_MAX);
  localparam logic [3:0]         SPEED_RST   = 4'((SPEED_INIT < SPEED_MAX) ? SPEED_INIT : SPEED_MAX);

  state_t             state_q, state_d;
  logic               fire_q;
  logic               fire_rise;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               armed_q, armed_d;
  logic [SCORE_W-1:0] score_q, score_d;
  logic [3:0]         lives_q, lives_d;
  logic [7:0]         level_q, level_d;

  logic               player_rst_q, player_rst_d;
  logic               wave_rst_q, wave_rst_d;
  logic               freeze_q, freeze_d;
  logic               game_over_q, game_over_d;
  logic [3:0]         speed_q, speed_d;

  logic [SCORE_W:0]   score_sum;
  logic [8:0]         speed_sum;
  logic               clear_done;
  logic               death_done;
  logic               restart_ok;

  // fire_q resets high so a button held through reset never reads as a press.
  assign fire_rise  = bus.fire & ~fire_q;
  assign score_sum  = {1'b0, score_q} + HIT_INC;
  assign clear_done = bus.fsync && (cnt_q >= CLEAR_LAST);
  assign death_done = bus.fsync && (cnt_q >= DEATH_LAST);
  assign restart_ok = (cnt_q >= DEATH_DONE);
  assign speed_sum  = SPEED_BASE + {1'b0, level_d};

  always_ff @(posedge pixel_clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_ATTRACT;
      fire_q       <= 1'b1;
      cnt_q        <= '0;
      armed_q      <= 1'b0;
      score_q      <= '0;
      lives_q      <= LIVES_INIT;
      level_q      <= '0;
      player_rst_q <= 1'b1;
      wave_rst_q   <= 1'b1;
      freeze_q     <= 1'b0;
      game_over_q  <= 1'b0;
      speed_q      <= SPEED_RST;
    end else begin
      state_q      <= state_d;
      fire_q       <= bus.fire;
      cnt_q        <= cnt_d;
      armed_q      <= armed_d;
      score_q      <= score_d;
      lives_q      <= lives_d;
      level_q      <= level_d;
      player_rst_q <= player_rst_d;
      wave_rst_q   <= wave_rst_d;
      freeze_q     <= freeze_d;
      game_over_q  <= game_over_d;
      speed_q      <= speed_d;
    end
  end

  always_comb begin
    state_d = state_q;
    score_d = score_q;
    lives_d = lives_q;
    level_d = level_q;

    case (state_q)
      ST_ATTRACT: begin
        if (fire_rise) begin
          state_d = ST_PLAY;
          score_d = '0;
          lives_d = LIVES_INIT;
          level_d = '0;
        end
      end
      ST_PLAY: begin
        // A kill landing on the same edge as the player's death still scores.
        if (bus.alien_hit) begin
          score_d = score_sum[SCORE_W] ? '1 : score_sum[SCORE_W-1:0];
        end
        if (bus.player_hit) begin
          if (lives_q <= 4'd1) begin
            state_d = ST_GAME_OVER;
            lives_d = '0;
          end else begin
            state_d = ST_DYING;
            lives_d = lives_q - 4'd1;
          end
        end else if (armed_q && (bus.aliens_remaining == ALIEN_W'(0))) begin
          state_d = ST_WAVE_CLEAR;
        end
      end
      ST_WAVE_CLEAR: begin
        if (clear_done) begin
          state_d = ST_PLAY;
          level_d = (level_q == 8'hFF) ? level_q : level_q + 8'd1;
        end
      end
      ST_DYING: begin
        if (death_done) state_d = ST_PLAY;
      end
      ST_GAME_OVER: begin
        if (fire_rise && restart_ok) state_d = ST_ATTRACT;
      end
      default: state_d = ST_ATTRACT;
    endcase
  end

  // Every state entry restarts the frame count and disarms; a coinciding
  // fsync is spent on the transition rather than counted or arming.
  always_comb begin
    cnt_d   = cnt_q;
    armed_d = armed_q;
    if (state_d != state_q) begin
      cnt_d   = '0;
      armed_d = 1'b0;
    end else if (bus.fsync) begin
      if (cnt_q < CNT_SAT) cnt_d = cnt_q + 1'b1;
      if (state_q == ST_PLAY) armed_d = 1'b1;
    end
  end

  always_comb begin
    player_rst_d = 1'b0;
    wave_rst_d   = 1'b0;
    freeze_d     = 1'b0;
    game_over_d  = 1'b0;
    case (state_d)
      ST_ATTRACT: begin
        player_rst_d = 1'b1;
        wave_rst_d   = 1'b1;
      end
      ST_WAVE_CLEAR: begin
        player_rst_d = 1'b1;
        wave_rst_d   = 1'b1;
      end
      ST_DYING: begin
        player_rst_d = 1'b1;
        freeze_d     = 1'b1;
      end
      ST_GAME_OVER: begin
        freeze_d     = 1'b1;
        game_over_d  = 1'b1;
      end
      default: ;
    endcase
    speed_d = (speed_sum > SPEED_CAP) ? SPEED_CAP[3:0] : speed_sum[3:0];
  end

  assign bus.state       = state_q;
  assign bus.player_rst  = player_rst_q;
  assign bus.wave_rst    = wave_rst_q;
  assign bus.freeze      = freeze_q;
  assign bus.game_over   = game_over_q;
  assign bus.enemy_speed = speed_q;
  assign bus.score       = score_q;
  assign bus.lives       = lives_q;
  assign bus.level       = level_q;

endmodule

// File: tb/tb_game_sequencer.sv
// Bench for game_sequencer: directed game script plus random play, checked
// cycle by cycle against a phase-level model through an expected queue.
module tb_game_sequencer;

  localparam int EXP_W   = 39;
  localparam int LIVES0  = 2;
  localparam int CLEAR_N = 3;
  localparam int DEATH_N = 2;
  localparam int HIT_PTS = 10;
  localparam int SPD0    = 1;
  localparam int SPD_TOP = 6;

  logic clk;
  logic rst;

  game_sequencer_if #(.NUM_ALIENS(20), .SCORE_W(16)) bus ();

  game_sequencer #(
    .NUM_ALIENS(20), .START_LIVES(LIVES0), .SPEED_INIT(SPD0), .SPEED_MAX(SPD_TOP),
    .SCORE_PER_HIT(HIT_PTS), .SCORE_W(16), .CLEAR_FRAMES(CLEAR_N), .DEATH_FRAMES(DEATH_N)
  ) dut (
    .pixel_clk (clk),
    .rst       (rst),
    .bus       (bus)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- reference model ----------------
  // Phases: 0 attract, 1 play, 2 wave clear, 3 dying, 4 game over.
  bit pr_tab [0:4] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
  bit wr_tab [0:4] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
  bit fz_tab [0:4] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};

  int m_phase, m_frames, m_score, m_lives, m_level;
  bit m_armed, m_fire_prev;

  task automatic model_reset();
    m_phase = 0; m_frames = 0; m_armed = 0;
    m_score = 0; m_lives = LIVES0; m_level = 0; m_fire_prev = 1;
  endtask

  task automatic model_step(input bit f, input bit fs, input bit ah, input bit ph,
                            input int ar, input bit r);
    bit rise;
    int nxt;
    if (r) begin
      model_reset();
      return;
    end
    rise = f && !m_fire_prev;
    m_fire_prev = f;
    nxt = m_phase;
    if (m_phase == 0) begin
      if (rise) begin nxt = 1; m_score = 0; m_lives = LIVES0; m_level = 0; end
    end else if (m_phase == 1) begin
      if (ah) m_score = (m_score + HIT_PTS > 65535) ? 65535 : m_score + HIT_PTS;
      if (ph) begin
        m_lives = m_lives - 1;
        nxt = (m_lives == 0) ? 4 : 3;
      end else if (m_armed && ar == 0) nxt = 2;
    end else if (m_phase == 2) begin
      if (fs && m_frames + 1 >= CLEAR_N) begin
        nxt = 1;
        m_level = (m_level == 255) ? 255 : m_level + 1;
      end
    end else if (m_phase == 3) begin
      if (fs && m_frames + 1 >= DEATH_N) nxt = 1;
    end else begin
      if (rise && m_frames >= DEATH_N) nxt = 0;
    end
    if (nxt != m_phase) begin
      m_frames = 0;
      m_armed  = 0;
    end else if (fs) begin
      m_frames = m_frames + 1;
      if (m_phase == 1) m_armed = 1;
    end
    m_phase = nxt;
  endtask

  function automatic logic [EXP_W-1:0] model_vec();
    int spd;
    spd = (SPD0 + m_level > SPD_TOP) ? SPD_TOP : SPD0 + m_level;
    return {3'(m_phase), pr_tab[m_phase], wr_tab[m_phase], fz_tab[m_phase],
            (m_phase == 4), 4'(spd), 16'(m_score), 4'(m_lives), 8'(m_level)};
  endfunction

  // ---------------- scoreboard ----------------
  logic [EXP_W-1:0] exp_q[$];
  int checks = 0;
  int errors = 0;
  int cycle  = 0;

  function automatic logic [EXP_W-1:0] dut_vec();
    return {bus.state, bus.player_rst, bus.wave_rst, bus.freeze, bus.game_over,
            bus.enemy_speed, bus.score, bus.lives, bus.level};
  endfunction

  always @(negedge clk) begin
    logic [EXP_W-1:0] want;
    logic [EXP_W-1:0] got;
    cycle++;
    if (exp_q.size() > 0) begin
      want = exp_q.pop_front();
      got  = dut_vec();
      checks++;
      if (got !== want) begin
        errors++;
        $display("FAIL outputs cycle %0d actual st=%0d pr/wr/fz/go=%b%b%b%b spd=%0d sc=%0d lv=%0d lvl=%0d required st=%0d pr/wr/fz/go=%b%b%b%b spd=%0d sc=%0d lv=%0d lvl=%0d",
                 cycle, got[38:36], got[35], got[34], got[33], got[32], got[31:28], got[27:12], got[11:8], got[7:0],
                 want[38:36], want[35], want[34], want[33], want[32], want[31:28], want[27:12], want[11:8], want[7:0]);
      end
    end
  end

  // ---------------- driver tasks ----------------
  bit cur_fire;
  int cur_ar;

  task automatic step(input bit fs, input bit ah, input bit ph);
    bus.fire             = cur_fire;
    bus.fsync            = fs;
    bus.alien_hit        = ah;
    bus.player_hit       = ph;
    bus.aliens_remaining = 5'(cur_ar);
    @(posedge clk);
    model_step(cur_fire, fs, ah, ph, cur_ar, rst);
    exp_q.push_back(model_vec());
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0);
  endtask

  task automatic frame();
    step(1'b1, 1'b0, 1'b0);
    idle(1);
  endtask

  task automatic press();
    cur_fire = 1'b0; idle(1);
    cur_fire = 1'b1; idle(1);
  endtask

  task automatic async_reset_check();
    logic [EXP_W-1:0] want;
    @(negedge clk);
    #1 rst = 1'b1;
    #1;
    want = {3'd0, 1'b1, 1'b1, 1'b0, 1'b0, 4'(SPD0), 16'd0, 4'(LIVES0), 8'd0};
    checks++;
    if (dut_vec() !== want) begin
      errors++;
      $display("FAIL async_reset actual %h required %h", dut_vec(), want);
    end
    model_reset();
    @(posedge clk);
    #1;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst = 1'b1;
    cur_fire = 1'b1;
    cur_ar = 20;
    bus.fire = 1'b1; bus.fsync = 1'b0; bus.alien_hit = 1'b0;
    bus.player_hit = 1'b0; bus.aliens_remaining = 5'd20;
    model_reset();
    @(posedge clk); #1;
    idle(2);
    rst = 1'b0;
    idle(3);                      // fire held across reset release: no start
    press();                      // start a game
    cur_ar = 0;
    idle(3);                      // unarmed: zero count ignored
    frame();                      // arms, then wave clear
    cur_ar = 20;
    frame(); frame(); frame();    // back to play, level 1
    step(1'b0, 1'b1, 1'b0); step(1'b0, 1'b1, 1'b0); step(1'b0, 1'b1, 1'b0);
    idle(1);
    frame();                      // arm again
    cur_ar = 0;
    step(1'b0, 1'b1, 1'b1);       // hit + kill + empty wave together -> dying
    cur_ar = 20;
    step(1'b0, 1'b1, 1'b0);       // kill ignored while dying
    frame(); frame();             // back to play
    step(1'b0, 1'b0, 1'b1);       // last life -> game over
    idle(1);
    frame();
    press();                      // too early
    frame();
    press();                      // accepted -> attract
    idle(2);
    press();
    step(1'b0, 1'b0, 1'b1);       // dying
    idle(1);
    async_reset_check();
    idle(2);
    rst = 1'b0;
    idle(2);

    // random play
    for (int i = 0; i < 2500; i++) begin
      if ($urandom_range(0, 3) == 0) cur_fire = ~cur_fire;
      cur_ar = ($urandom_range(0, 3) == 0) ? 0 : int'($urandom_range(1, 20));
      step($urandom_range(0, 2) == 0, $urandom_range(0, 4) == 0, $urandom_range(0, 25) == 0);
    end

    @(negedge clk);
    #1;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL queue_drain actual %0d required 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
